bus_burst_ram_slave: RTL and testbench

Bus-side burst memory slave for the shared address/data bus used by the custom-instruction DMA (`ramDmaCi`). It sits directly downstream of the DMA master. It decodes a base-address window, absorbs write bursts into an on-chip word RAM and returns read bursts with a fixed latency. All outputs are zero when it is not driving the bus, so they can be OR-combined with other bus agents.

---
 rtl/bus_burst_ram_slave.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_bus_burst_ram_slave.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_burst_ram_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : bus_burst_ram_slave
//  Purpose  : Burst memory slave on the shared address/data bus downstream of
//             the ramDmaCi DMA master. Decodes a base-address window, stores
//             write bursts into an on-chip 32-bit word RAM (byte-masked) and
//             returns read bursts after a fixed latency. Every output is zero
//             whenever the slave is not driving the bus, so outputs can be
//             OR-combined with other bus agents.
//
//  Parameters
//    baseAddress : start of the decoded window (aligned to the window size)
//    addrWidth   : log2 of RAM depth in 32-bit words
//    readLatency : cycles from begin-transaction to first read beat (1..15)
//
//  Ports
//    clock, reset          : system clock, synchronous active-high reset
//    beginTransactionIn    : one-cycle transaction start
//    addressDataIn         : byte address in begin cycle, write data on beats
//    readNotWriteIn        : 1 = read, sampled in the begin cycle
//    burstSizeIn           : beats - 1, sampled in the begin cycle
//    byteEnablesIn         : byte mask for every write beat, begin cycle
//    dataValidIn           : write beat strobe
//    endTransactionIn      : master end-of-write / abort
//    addressDataOut        : read data, zero outside valid beats
//    dataValidOut          : read beat strobe
//    endTransactionOut     : slave end-of-read, one cycle
//    busErrorOut           : one-cycle error pulse
//
//  Revision : 1.0 - initial release
// ============================================================================
module bus_burst_ram_slave #(
    parameter logic [31:0] baseAddress = 32'h5000_0000,
    parameter int unsigned addrWidth   = 10,
    parameter int unsigned readLatency = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic [31:0] addressDataIn,
    input  logic        readNotWriteIn,
    input  logic [7:0]  burstSizeIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    output logic [31:0] addressDataOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    output logic        busErrorOut
);

    localparam int unsigned c_DEPTH = 1 << addrWidth;
    // Wide enough to hold last word index plus the largest burst offset.
    localparam int unsigned c_SUM_W = (addrWidth >= 8) ? addrWidth + 1 : 9;
    localparam logic [c_SUM_W-1:0] c_LAST_WORD = c_SUM_W'(c_DEPTH - 1);
    localparam logic [3:0] c_WAIT_LOAD = 4'(readLatency - 1);
    localparam bit c_HAS_WAIT = (readLatency > 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_READ_WAIT = 3'd2,
        S_READ      = 3'd3,
        S_END       = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;

    logic [addrWidth-1:0]   r_addr;
    logic [8:0]             r_remain;
    logic [3:0]             r_waitCnt;
    logic [3:0]             r_be;
    logic                   r_errIsRead;
    logic                   r_errOneShot;
    logic                   r_errFirst;

    logic [31:0]            r_mem [c_DEPTH];
    logic [31:0]            r_rdData;

    logic [addrWidth-1:0]   w_wa;
    logic [addrWidth-1:0]   w_ramAddr;
    logic [c_SUM_W-1:0]     w_burstSum;
    logic                   w_hit;
    logic                   w_rangeErr;
    logic                   w_accept;
    logic                   w_ramWe;
    logic                   w_overrun;
    logic [1:0]             w_unusedByteOffset;

    // ------------------------------------------------------------------
    // Address decode and burst range check
    // ------------------------------------------------------------------
    assign w_wa               = addressDataIn[addrWidth+1:2];
    assign w_hit              = (addressDataIn[31:addrWidth+2] == baseAddress[31:addrWidth+2]);
    assign w_burstSum         = c_SUM_W'(w_wa) + c_SUM_W'(burstSizeIn);
    assign w_rangeErr         = (w_burstSum > c_LAST_WORD);
    // Byte offset within a word has no meaning for a word RAM.
    assign w_unusedByteOffset = addressDataIn[1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and RAM port control
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        w_ramAddr   = r_addr;
        w_ramWe     = 1'b0;
        w_accept    = 1'b0;
        w_overrun   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Pre-fetch the first word during the begin cycle so a
                // latency of one cycle can still deliver beat 0 on time.
                w_ramAddr = w_wa;
                if (beginTransactionIn && w_hit) begin
                    w_accept = 1'b1;
                    if (w_rangeErr) begin
                        w_stateNext = S_ERROR;
                    end else if (readNotWriteIn) begin
                        w_stateNext = c_HAS_WAIT ? S_READ_WAIT : S_READ;
                    end else begin
                        w_stateNext = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                w_ramAddr = r_addr;
                if (dataValidIn) begin
                    if (r_remain != 9'd0) begin
                        w_ramWe = 1'b1;
                    end else begin
                        w_overrun   = 1'b1;
                        w_stateNext = S_ERROR;
                    end
                end
                if (endTransactionIn && !w_overrun) begin
                    w_stateNext = S_IDLE;
                end
            end

            S_READ_WAIT: begin
                // Holds the first word address so its data is registered
                // exactly one cycle before beat 0.
                w_ramAddr = r_addr;
                if (endTransactionIn) begin
                    w_stateNext = S_IDLE;
                end else if (r_waitCnt <= 4'd1) begin
                    w_stateNext = S_READ;
                end
            end

            S_READ: begin
                // Current beat's data is already registered; fetch the next.
                w_ramAddr = r_addr + 1'b1;
                if (endTransactionIn) begin
                    w_stateNext = S_IDLE;
                end else if (r_remain == 9'd0) begin
                    w_stateNext = S_END;
                end
            end

            S_END: begin
                w_stateNext = S_IDLE;
            end

            S_ERROR: begin
                if (r_errOneShot || endTransactionIn) begin
                    w_stateNext = S_IDLE;
                end
            end

            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction context: address, beat budget, latency count, error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr       <= '0;
            r_remain     <= 9'd0;
            r_waitCnt    <= 4'd0;
            r_be         <= 4'd0;
            r_errIsRead  <= 1'b0;
            r_errOneShot <= 1'b0;
            r_errFirst   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr       <= w_wa;
                        r_be         <= byteEnablesIn;
                        // Reads count beats still to issue after the current
                        // one; writes count beats still allowed.
                        r_remain     <= readNotWriteIn ? {1'b0, burstSizeIn}
                                                       : {1'b0, burstSizeIn} + 9'd1;
                        r_waitCnt    <= c_WAIT_LOAD;
                        // A read range error completes in one cycle with an
                        // end pulse; a write range error drains beats.
                        r_errIsRead  <= readNotWriteIn;
                        r_errOneShot <= readNotWriteIn;
                        r_errFirst   <= 1'b1;
                    end
                end

                S_WRITE: begin
                    if (w_ramWe) begin
                        r_addr   <= r_addr + 1'b1;
                        r_remain <= r_remain - 9'd1;
                    end
                    if (w_overrun) begin
                        r_errIsRead  <= 1'b0;
                        // End already seen alongside the overrun beat: no
                        // further end will come, so leave after the pulse.
                        r_errOneShot <= endTransactionIn;
                        r_errFirst   <= 1'b1;
                    end
                end

                S_READ_WAIT: begin
                    r_waitCnt <= r_waitCnt - 4'd1;
                end

                S_READ: begin
                    r_addr   <= r_addr + 1'b1;
                    r_remain <= r_remain - 9'd1;
                end

                S_ERROR: begin
                    r_errFirst <= 1'b0;
                end

                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Single-port word RAM with registered read data; contents survive reset
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_ramWe) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_ramAddr][8*i +: 8] <= addressDataIn[8*i +: 8];
                end
            end
        end
        r_rdData <= r_mem[w_ramAddr];
    end

    // ------------------------------------------------------------------
    // Bus outputs: derived only from registers, zero when idle
    // ------------------------------------------------------------------
    assign dataValidOut      = (r_state == S_READ);
    assign addressDataOut    = dataValidOut ? r_rdData : 32'h0;
    assign endTransactionOut = (r_state == S_END) || ((r_state == S_ERROR) && r_errIsRead);
    assign busErrorOut       = (r_state == S_ERROR) && r_errFirst;

endmodule
`default_nettype wire

// File: tb/tb_bus_burst_ram_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_bus_burst_ram_slave
//  Purpose  : Self-checking bench for bus_burst_ram_slave. A word-array model
//             of the RAM tracks every accepted write; read bursts, error
//             pulses and end strobes are compared against expectations
//             derived from the window/range/latency rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_burst_ram_slave;

    localparam logic [31:0] BASE  = 32'h5000_0000;
    localparam int          AW    = 10;
    localparam int          DEPTH = 1 << AW;
    localparam int          LAT   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        beginTransactionIn = 1'b0;
    logic [31:0] addressDataIn = 32'h0;
    logic        readNotWriteIn = 1'b0;
    logic [7:0]  burstSizeIn = 8'h0;
    logic [3:0]  byteEnablesIn = 4'h0;
    logic        dataValidIn = 1'b0;
    logic        endTransactionIn = 1'b0;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busErrorOut;

    bus_burst_ram_slave #(
        .baseAddress (BASE),
        .addrWidth   (AW),
        .readLatency (LAT)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .beginTransactionIn(beginTransactionIn),
        .addressDataIn     (addressDataIn),
        .readNotWriteIn    (readNotWriteIn),
        .burstSizeIn       (burstSizeIn),
        .byteEnablesIn     (byteEnablesIn),
        .dataValidIn       (dataValidIn),
        .endTransactionIn  (endTransactionIn),
        .addressDataOut    (addressDataOut),
        .dataValidOut      (dataValidOut),
        .endTransactionOut (endTransactionOut),
        .busErrorOut       (busErrorOut)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [DEPTH];

    // Observations captured by the bus drivers
    logic [31:0] rdData[$];
    int          rdOfs[$];
    int          endCnt, endOfs, errCnt, errOfs, stray;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        beginTransactionIn = 1'b0;
        addressDataIn      = 32'h0;
        readNotWriteIn     = 1'b0;
        burstSizeIn        = 8'h0;
        byteEnablesIn      = 4'h0;
        dataValidIn        = 1'b0;
        endTransactionIn   = 1'b0;
    endtask

    function automatic logic [31:0] wa_addr(input int wa);
        return BASE + 32'(wa) * 32'd4 + 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Model: an in-range write stores min(n, burst+1) beats from wa upward.
    task automatic model_write(input int wa, input int burst, input logic [3:0] be,
                               input logic [31:0] d[$], input int n);
        logic [31:0] m;
        m = be_mask(be);
        if (wa + burst > DEPTH - 1) return;
        for (int j = 0; j < n && j <= burst; j++) begin
            model[wa + j] = (model[wa + j] & ~m) | (d[j] & m);
        end
    endtask

    // Begin a write, present n beats on consecutive cycles, end endDelay
    // cycles after the last beat, then watch tail more cycles.
    task automatic do_write(input logic [31:0] addr, input int burst, input logic [3:0] be,
                            input logic [31:0] d[$], input int n, input int endDelay,
                            input int tail);
        int endK;
        errCnt = 0; errOfs = -1; stray = 0;
        beginTransactionIn = 1'b1;
        addressDataIn      = addr;
        readNotWriteIn     = 1'b0;
        burstSizeIn        = 8'(burst);
        byteEnablesIn      = be;
        tick();
        idle_inputs();
        endK = ((n == 0) ? 1 : n) + endDelay;
        for (int k = 1; k <= endK + tail; k++) begin
            dataValidIn      = (k <= n);
            addressDataIn    = 32'h0;
            if (k <= n) addressDataIn = d[k-1];
            endTransactionIn = (k == endK);
            if (busErrorOut) begin errCnt++; if (errOfs < 0) errOfs = k; end
            if (dataValidOut || endTransactionOut || (addressDataOut != 32'h0)) stray++;
            tick();
        end
        idle_inputs();
    endtask

    // Begin a read and record every output event for window cycles.
    task automatic do_read(input logic [31:0] addr, input int burst, input int window);
        rdData.delete(); rdOfs.delete();
        endCnt = 0; endOfs = -1; errCnt = 0; errOfs = -1; stray = 0;
        beginTransactionIn = 1'b1;
        addressDataIn      = addr;
        readNotWriteIn     = 1'b1;
        burstSizeIn        = 8'(burst);
        byteEnablesIn      = 4'($urandom_range(0, 15));
        tick();
        idle_inputs();
        for (int k = 1; k <= window; k++) begin
            if (dataValidOut) begin
                rdData.push_back(addressDataOut);
                rdOfs.push_back(k);
            end else if (addressDataOut != 32'h0) begin
                stray++;
            end
            if (endTransactionOut) begin endCnt++; if (endOfs < 0) endOfs = k; end
            if (busErrorOut) begin errCnt++; if (errOfs < 0) errOfs = k; end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) tick();
        checks++; if (dataValidOut !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", dataValidOut); end
        checks++; if (addressDataOut !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", addressDataOut); end
        checks++; if (endTransactionOut !== 1'b0) begin failures++; $display("FAIL reset_end: got %b expected 0", endTransactionOut); end
        checks++; if (busErrorOut !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", busErrorOut); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        logic [31:0] q[$];
        for (int b = 0; b < DEPTH / 256; b++) begin
            q.delete();
            for (int j = 0; j < 256; j++) q.push_back($urandom);
            do_write(wa_addr(b * 256), 255, 4'hF, q, 256, 0, 2);
            model_write(b * 256, 255, 4'hF, q, 256);
            checks++; if (errCnt != 0 || stray != 0) begin failures++; $display("FAIL fill_err: got err=%0d stray=%0d expected 0 0", errCnt, stray); end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] q[$];
        logic [31:0] expd [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        q = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_write(BASE + 32'h10, 3, 4'hF, q, 4, 1, 2);
        model_write(4, 3, 4'hF, q, 4);
        checks++; if (errCnt != 0) begin failures++; $display("FAIL wr_err: got %0d expected 0", errCnt); end
        do_read(BASE + 32'h10, 3, LAT + 6);
        checks++; if (rdData.size() != 4) begin failures++; $display("FAIL rd_beats: got %0d expected 4", rdData.size()); end
        for (int i = 0; i < rdData.size() && i < 4; i++) begin
            checks++; if (rdData[i] !== expd[i] || rdOfs[i] != LAT + i) begin failures++; $display("FAIL rd_beat%0d: got %h@%0d expected %h@%0d", i, rdData[i], rdOfs[i], expd[i], LAT + i); end
        end
        checks++; if (endCnt != 1 || endOfs != 6) begin failures++; $display("FAIL rd_end: got cnt=%0d ofs=%0d expected 1 6", endCnt, endOfs); end
    endtask

    task automatic test_byte_enables();
        logic [31:0] q[$];
        q = '{32'hAABBCCDD};
        do_write(BASE, 0, 4'hF, q, 1, 0, 2);
        model_write(0, 0, 4'hF, q, 1);
        q = '{32'h0000_0000};
        do_write(BASE, 0, 4'b0101, q, 1, 0, 2);
        model_write(0, 0, 4'b0101, q, 1);
        do_read(BASE, 0, LAT + 3);
        checks++; if (rdData.size() != 1 || rdData[0] !== 32'hAA00CC00) begin failures++; $display("FAIL be_merge: got %h (beats %0d) expected aa00cc00", (rdData.size() > 0) ? rdData[0] : 32'h0, rdData.size()); end
    endtask

    task automatic test_range_error();
        logic [31:0] q[$];
        do_read(BASE + 32'hFFC, 1, LAT + 4);
        checks++; if (rdData.size() != 0) begin failures++; $display("FAIL rerr_beats: got %0d expected 0", rdData.size()); end
        checks++; if (errCnt != 1 || errOfs != 1) begin failures++; $display("FAIL rerr_err: got cnt=%0d ofs=%0d expected 1 1", errCnt, errOfs); end
        checks++; if (endCnt != 1 || endOfs != 1) begin failures++; $display("FAIL rerr_end: got cnt=%0d ofs=%0d expected 1 1", endCnt, endOfs); end
        // Last word with a single beat is exactly in range.
        do_read(BASE + 32'hFFC, 0, LAT + 3);
        checks++; if (rdData.size() != 1 || rdData[0] !== model[DEPTH-1] || errCnt != 0 || endOfs != LAT + 1) begin failures++; $display("FAIL rlast: got beats=%0d err=%0d end=%0d expected 1 0 %0d", rdData.size(), errCnt, endOfs, LAT + 1); end
        // Write range error: pulse at T+1, nothing stored.
        q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        do_write(wa_addr(DEPTH - 4), 4, 4'hF, q, 5, 0, 2);
        model_write(DEPTH - 4, 4, 4'hF, q, 5);
        checks++; if (errCnt != 1 || errOfs != 1) begin failures++; $display("FAIL werr: got cnt=%0d ofs=%0d expected 1 1", errCnt, errOfs); end
        do_read(wa_addr(DEPTH - 4), 3, LAT + 6);
        for (int i = 0; i < 4; i++) begin
            checks++; if (i >= rdData.size() || rdData[i] !== model[DEPTH - 4 + i]) begin failures++; $display("FAIL werr_keep%0d: got %h expected %h", i, (i < rdData.size()) ? rdData[i] : 32'h0, model[DEPTH - 4 + i]); end
        end
    endtask

    task automatic test_overrun();
        logic [31:0] q[$];
        q = '{32'h5, 32'h6};
        do_write(wa_addr(300), 0, 4'hF, q, 2, 2, 2);
        model_write(300, 0, 4'hF, q, 2);
        checks++; if (errCnt != 1 || errOfs != 3) begin failures++; $display("FAIL ovr_err: got cnt=%0d ofs=%0d expected 1 3", errCnt, errOfs); end
        do_read(wa_addr(300), 1, LAT + 4);
        checks++; if (rdData.size() != 2 || rdData[0] !== 32'h5 || rdData[1] !== model[301]) begin failures++; $display("FAIL ovr_data: got %h %h expected 5 %h", (rdData.size() > 0) ? rdData[0] : 32'h0, (rdData.size() > 1) ? rdData[1] : 32'h0, model[301]); end
        // Underrun: three beats of an eight-beat burst, no error.
        q = '{32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};
        do_write(wa_addr(310), 7, 4'hF, q, 3, 0, 2);
        model_write(310, 7, 4'hF, q, 3);
        checks++; if (errCnt != 0) begin failures++; $display("FAIL udr_err: got %0d expected 0", errCnt); end
        do_read(wa_addr(310), 7, LAT + 10);
        for (int i = 0; i < 8; i++) begin
            checks++; if (i >= rdData.size() || rdData[i] !== model[310 + i]) begin failures++; $display("FAIL udr_data%0d: got %h expected %h", i, (i < rdData.size()) ? rdData[i] : 32'h0, model[310 + i]); end
        end
    endtask

    task automatic test_miss_abort();
        logic [31:0] q[$];
        int          act;
        do_read(32'h4000_0000, 3, 8);
        checks++; if (rdData.size() != 0 || endCnt != 0 || errCnt != 0 || stray != 0) begin failures++; $display("FAIL miss_rd: got beats=%0d end=%0d err=%0d stray=%0d expected all 0", rdData.size(), endCnt, errCnt, stray); end
        // Just above the window: write must be ignored.
        q = '{32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003};
        do_write(BASE + 32'h1010, 3, 4'hF, q, 4, 0, 2);
        checks++; if (errCnt != 0 || stray != 0) begin failures++; $display("FAIL miss_wr: got err=%0d stray=%0d expected 0 0", errCnt, stray); end
        do_read(BASE + 32'h10, 3, LAT + 6);
        for (int i = 0; i < 4; i++) begin
            checks++; if (i >= rdData.size() || rdData[i] !== model[4 + i]) begin failures++; $display("FAIL miss_keep%0d: got %h expected %h", i, (i < rdData.size()) ? rdData[i] : 32'h0, model[4 + i]); end
        end
        // Abort an eight-beat read during its second beat.
        beginTransactionIn = 1'b1; addressDataIn = wa_addr(200); readNotWriteIn = 1'b1; burstSizeIn = 8'd7;
        tick();
        idle_inputs();
        act = 0;
        for (int k = 1; k <= LAT + 1; k++) begin
            if (k >= LAT) begin
                checks++; if (dataValidOut !== 1'b1 || addressDataOut !== model[200 + k - LAT]) begin failures++; $display("FAIL abort_beat%0d: got v=%b %h expected 1 %h", k - LAT, dataValidOut, addressDataOut, model[200 + k - LAT]); end
            end
            endTransactionIn = (k == LAT + 1);
            tick();
        end
        idle_inputs();
        for (int k = 0; k < 10; k++) begin
            if (dataValidOut || endTransactionOut || busErrorOut || addressDataOut != 32'h0) act++;
            if (k == 0) begin
                // First idle cycle after abort: next begin must be accepted.
                checks++; if (act != 0) begin failures++; $display("FAIL abort_idle: got activity=%0d expected 0", act); end
                break;
            end
        end
        do_read(wa_addr(500), 2, LAT + 4);
        checks++; if (rdData.size() != 3 || rdData[0] !== model[500] || rdData[2] !== model[502] || endOfs != LAT + 3) begin failures++; $display("FAIL abort_next: got beats=%0d end=%0d expected 3 %0d", rdData.size(), endOfs, LAT + 3); end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] q[$];
        int          act;
        for (int j = 0; j < 8; j++) q.push_back($urandom);
        do_write(wa_addr(100), 7, 4'hF, q, 8, 0, 2);
        model_write(100, 7, 4'hF, q, 8);
        beginTransactionIn = 1'b1; addressDataIn = wa_addr(100); readNotWriteIn = 1'b1; burstSizeIn = 8'd7;
        tick();
        idle_inputs();
        repeat (LAT - 1) tick();
        checks++; if (dataValidOut !== 1'b1 || addressDataOut !== model[100]) begin failures++; $display("FAIL rst_beat0: got v=%b %h expected 1 %h", dataValidOut, addressDataOut, model[100]); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({dataValidOut, endTransactionOut, busErrorOut} !== 3'b000 || addressDataOut !== 32'h0) begin failures++; $display("FAIL rst_outs: got v=%b e=%b err=%b d=%h expected 0", dataValidOut, endTransactionOut, busErrorOut, addressDataOut); end
        act = 0;
        for (int k = 0; k < 10; k++) begin
            if (dataValidOut || endTransactionOut || busErrorOut || addressDataOut != 32'h0) act++;
            tick();
        end
        checks++; if (act != 0) begin failures++; $display("FAIL rst_quiet: got %0d active cycles expected 0", act); end
        do_read(wa_addr(100), 7, LAT + 10);
        for (int i = 0; i < 8; i++) begin
            checks++; if (i >= rdData.size() || rdData[i] !== model[100 + i]) begin failures++; $display("FAIL rst_keep%0d: got %h expected %h", i, (i < rdData.size()) ? rdData[i] : 32'h0, model[100 + i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        for (int j = 0; j < 4; j++) q.push_back($urandom);
        // Write with end on the last beat, then a read in the first idle cycle.
        do_write(wa_addr(640), 3, 4'hF, q, 4, 0, 0);
        model_write(640, 3, 4'hF, q, 4);
        do_read(wa_addr(640), 3, LAT + 4);
        for (int i = 0; i < 4; i++) begin
            checks++; if (i >= rdData.size() || rdData[i] !== model[640 + i] || rdOfs[i] != LAT + i) begin failures++; $display("FAIL b2b_wr%0d: got %h@%0d expected %h@%0d", i, (i < rdData.size()) ? rdData[i] : 32'h0, (i < rdOfs.size()) ? rdOfs[i] : -1, model[640 + i], LAT + i); end
        end
        checks++; if (endCnt != 1 || endOfs != LAT + 4) begin failures++; $display("FAIL b2b_end1: got cnt=%0d ofs=%0d expected 1 %0d", endCnt, endOfs, LAT + 4); end
        // do_read window ended at the first idle cycle; begin again now.
        do_read(wa_addr(700), 1, LAT + 3);
        checks++; if (rdData.size() != 2 || rdData[0] !== model[700] || rdData[1] !== model[701] || endOfs != LAT + 2) begin failures++; $display("FAIL b2b_rd: got beats=%0d end=%0d expected 2 %0d", rdData.size(), endOfs, LAT + 2); end
        repeat (2) tick();
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int          wa, burst, n, dly, expErr, expOfs;
            bit          rnw, rangeErr;
            logic [3:0]  be;
            logic [31:0] q[$];
            burst    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
            wa       = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DEPTH - 20, DEPTH - 1)) : int'($urandom_range(0, DEPTH - 1));
            rangeErr = (wa + burst) > (DEPTH - 1);
            rnw      = 1'($urandom_range(0, 1));
            if (rnw) begin
                do_read(wa_addr(wa), burst, LAT + burst + 3);
                if (rangeErr) begin
                    checks++; if (rdData.size() != 0 || errOfs != 1 || errCnt != 1 || endOfs != 1 || endCnt != 1) begin failures++; $display("FAIL rnd_rerr t%0d: got beats=%0d err=%0d@%0d end=%0d@%0d expected 0 1@1 1@1", t, rdData.size(), errCnt, errOfs, endCnt, endOfs); end
                end else begin
                    checks++; if (rdData.size() != burst + 1) begin failures++; $display("FAIL rnd_beats t%0d: got %0d expected %0d", t, rdData.size(), burst + 1); end
                    for (int i = 0; i < rdData.size() && i <= burst; i++) begin
                        checks++; if (rdData[i] !== model[wa + i] || rdOfs[i] != LAT + i) begin failures++; $display("FAIL rnd_data t%0d b%0d: got %h@%0d expected %h@%0d", t, i, rdData[i], rdOfs[i], model[wa + i], LAT + i); end
                    end
                    checks++; if (endCnt != 1 || endOfs != LAT + burst + 1 || errCnt != 0) begin failures++; $display("FAIL rnd_end t%0d: got end=%0d@%0d err=%0d expected 1@%0d 0", t, endCnt, endOfs, errCnt, LAT + burst + 1); end
                end
                checks++; if (stray != 0) begin failures++; $display("FAIL rnd_stray t%0d: got %0d expected 0", t, stray); end
            end else begin
                be  = 4'($urandom_range(0, 15));
                n   = $urandom_range(0, burst + 2);
                dly = $urandom_range(0, 2);
                for (int j = 0; j < n; j++) q.push_back($urandom);
                do_write(wa_addr(wa), burst, be, q, n, dly, 2);
                model_write(wa, burst, be, q, n);
                if (rangeErr) begin expErr = 1; expOfs = 1; end
                else if (n > burst + 1) begin expErr = 1; expOfs = burst + 3; end
                else begin expErr = 0; expOfs = -1; end
                checks++; if (errCnt != expErr || errOfs != expOfs || stray != 0) begin failures++; $display("FAIL rnd_wr t%0d: got err=%0d@%0d stray=%0d expected %0d@%0d 0", t, errCnt, errOfs, stray, expErr, expOfs); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_byte_enables();
        test_range_error();
        test_overrun();
        test_miss_abort();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
